systolic_skew_feeder: RTL

West-edge input stage of the FP16 systolic MAC array. Accepts one row vector of LANES operands per beat over valid/ready and drives the array's west-edge `in_a` ports, one lane per array row. Lane i is delayed by i cycles so operands meet their north-edge partners in the correct PE. After the last beat it injects zeros until every product has reached the accumulators, then pulses `tile_done`.

---
 rtl/systolic_skew_feeder.sv | 100 ++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: west-edge skew stage for the systolic MAC array.
// Lane i is delayed i extra cycles; the tile is drained with zeros before tile_done pulses.
module systolic_skew_feeder #(
    parameter int WIDTH      = 16,
    parameter int LANES      = 4,
    parameter int ARRAY_COLS = 4,
    parameter int PE_LAT     = 2,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic [LANES*WIDTH-1:0] out_a,
    output logic                   out_active,
    output logic                   tile_done,
    output logic [CNT_W-1:0]       beat_count,
    output logic                   busy
);
    localparam int FLUSH_N = LANES - 1 + ARRAY_COLS + PE_LAT;
    localparam int FW      = $clog2(FLUSH_N + 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;
    logic [LANES-1:0] lane_act;

    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        count_d    = count_q;
        in_ready   = (state_q == IDLE) || (state_q == STREAM);
        accept     = in_valid && in_ready;
        tile_done  = state_q == DONE;
        busy       = state_q != IDLE;
        beat_count = count_q;
        out_active = |lane_act;
        case (state_q)
            IDLE, STREAM: if (accept) begin
                count_d = (state_q == IDLE) ? CNT_W'(1) : (&count_q ? count_q : count_q + CNT_W'(1));
                state_d = in_last ? FLUSH : STREAM;
                flush_d = in_last ? FW'(FLUSH_N) : flush_q;
            end
            FLUSH: begin
                flush_d = flush_q - FW'(1);
                state_d = (flush_q == FW'(1)) ? DONE : FLUSH;
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            flush_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            count_q <= count_d;
        end

    // Tag bits ride with the data so an accepted all-zero operand still reads as active.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [i:0][WIDTH-1:0] dat_q;
        logic [i:0]            tag_q;
        logic [WIDTH-1:0]      head;
        assign head = accept ? in_data[i*WIDTH +: WIDTH] : '0;
        if (i == 0) begin : g_head
            always_ff @(posedge clk or posedge reset)
                if (reset) begin
                    dat_q <= '0;
                    tag_q <= '0;
                end else begin
                    dat_q <= head;
                    tag_q <= accept;
                end
        end else begin : g_chain
            always_ff @(posedge clk or posedge reset)
                if (reset) begin
                    dat_q <= '0;
                    tag_q <= '0;
                end else begin
                    dat_q <= {dat_q[i-1:0], head};
                    tag_q <= {tag_q[i-1:0], accept};
                end
        end
        assign out_a[i*WIDTH +: WIDTH] = dat_q[i];
        assign lane_act[i]             = |tag_q;
    end
endmodule
